// File: rtl/intr_prio_cfg_loader.sv
// -----------------------------------------------------------------------------
// intr_prio_cfg_loader
// APB master sequencer that programs the NUM_INTR priority registers of the
// interrupt controller. On an accepted start it snapshots the priority table,
// writes index i to paddr=i for i = 0..NUM_INTR-1, optionally reads each
// register back and compares it with the value written, and stops on the first
// slave error, timeout or readback mismatch. Completion is a one-cycle done
// pulse; the first error is kept (code + address) until the next start.
//
// Ports
//   pclk_i        clock, rising edge
//   prst_i        synchronous active-high reset
//   start_i       begin a load sequence (sampled only in IDLE)
//   verify_en_i   enable readback compare (sampled with start_i)
//   prio_table_i  packed priorities, source i at [i*PRIO_W +: PRIO_W]
//   busy_o        sequence in progress
//   done_o        one-cycle end-of-sequence pulse
//   err_o         sticky error flag
//   err_code_o    0 none, 1 pslverr, 2 timeout, 3 readback mismatch
//   err_addr_o    paddr of the failing access
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request
//   prdata_i, pready_i, pslverr_i                    APB response
// -----------------------------------------------------------------------------
module intr_prio_cfg_loader #(
   parameter int NUM_INTR    = 16,
   parameter int PRIO_W      = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                       pclk_i,
   input  logic                       prst_i,
   input  logic                       start_i,
   input  logic                       verify_en_i,
   input  logic [NUM_INTR*PRIO_W-1:0] prio_table_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic [1:0]                 err_code_o,
   output logic [7:0]                 err_addr_o,
   output logic [7:0]                 paddr_o,
   output logic [7:0]                 pwdata_o,
   output logic                       pwrite_o,
   output logic                       psel_o,
   output logic                       penable_o,
   input  logic [7:0]                 prdata_i,
   input  logic                       pready_i,
   input  logic                       pslverr_i
);

   localparam int                 TBL_W    = NUM_INTR * PRIO_W;
   localparam int                 TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]         LAST_IDX = 8'(NUM_INTR - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_SLV  = 2'd1;
   localparam logic [1:0] ERR_TMO  = 2'd2;
   localparam logic [1:0] ERR_RDBK = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_SETUP  = 3'd1,
      S_WR_ACCESS = 3'd2,
      S_RD_SETUP  = 3'd3,
      S_RD_ACCESS = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   // Zero-extended priority of one source taken from a packed table.
   function automatic logic [7:0] prio_at(input logic [TBL_W-1:0] tbl,
                                          input logic [7:0]       idx);
      logic [7:0] v;
      v = 8'd0;
      v[PRIO_W-1:0] = tbl[int'(idx)*PRIO_W +: PRIO_W];
      return v;
   endfunction

   state_t             r_state;
   logic [7:0]         r_idx;
   logic [TMO_W-1:0]   r_tmo;
   logic [TBL_W-1:0]   r_snap;
   logic               r_verify;
   logic               r_err;
   logic [1:0]         r_err_code;
   logic [7:0]         r_err_addr;
   logic               r_busy;
   logic               r_done;
   logic [7:0]         r_paddr;
   logic [7:0]         r_pwdata;
   logic               r_pwrite;
   logic               r_psel;
   logic               r_penable;

   state_t             w_state_nxt;
   logic [7:0]         w_idx_nxt;
   logic [TMO_W-1:0]   w_tmo_nxt;
   logic [TBL_W-1:0]   w_snap_nxt;
   logic               w_verify_nxt;
   logic               w_err_nxt;
   logic [1:0]         w_err_code_nxt;
   logic [7:0]         w_err_addr_nxt;
   logic               w_adv;
   logic [7:0]         w_paddr_nxt;
   logic [7:0]         w_pwdata_nxt;
   logic               w_pwrite_nxt;
   logic               w_psel_nxt;
   logic               w_penable_nxt;

   // Next-state, index, timeout and first-error bookkeeping
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_tmo_nxt      = r_tmo;
      w_snap_nxt     = r_snap;
      w_verify_nxt   = r_verify;
      w_err_nxt      = r_err;
      w_err_code_nxt = r_err_code;
      w_err_addr_nxt = r_err_addr;
      w_adv          = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_snap_nxt     = prio_table_i;
               w_verify_nxt   = verify_en_i;
               w_err_nxt      = 1'b0;
               w_err_code_nxt = ERR_NONE;
               w_err_addr_nxt = 8'd0;
               w_idx_nxt      = 8'd0;
               w_state_nxt    = S_WR_SETUP;
            end else begin
               w_state_nxt    = S_IDLE;
            end
         end
         S_WR_SETUP: begin
            w_tmo_nxt   = '0;
            w_state_nxt = S_WR_ACCESS;
         end
         S_WR_ACCESS: begin
            if (pready_i) begin
               if (pslverr_i) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_SLV;
                  w_err_addr_nxt = r_idx;
                  w_state_nxt    = S_DONE;
               end else if (r_verify) begin
                  w_state_nxt    = S_RD_SETUP;
               end else begin
                  w_adv          = 1'b1;
               end
            end else if (r_tmo == TMO_LAST) begin
               // This wait cycle is the TIMEOUT_CYC-th one without pready
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_TMO;
               w_err_addr_nxt = r_idx;
               w_state_nxt    = S_DONE;
            end else begin
               w_tmo_nxt      = r_tmo + TMO_W'(1);
            end
         end
         S_RD_SETUP: begin
            w_tmo_nxt   = '0;
            w_state_nxt = S_RD_ACCESS;
         end
         S_RD_ACCESS: begin
            if (pready_i) begin
               if (pslverr_i) begin
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_SLV;
                  w_err_addr_nxt = r_idx;
                  w_state_nxt    = S_DONE;
               end else if (prdata_i != prio_at(r_snap, r_idx)) begin
                  // Full 8-bit compare: stray upper bits count as a mismatch
                  w_err_nxt      = 1'b1;
                  w_err_code_nxt = ERR_RDBK;
                  w_err_addr_nxt = r_idx;
                  w_state_nxt    = S_DONE;
               end else begin
                  w_adv          = 1'b1;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_err_nxt      = 1'b1;
               w_err_code_nxt = ERR_TMO;
               w_err_addr_nxt = r_idx;
               w_state_nxt    = S_DONE;
            end else begin
               w_tmo_nxt      = r_tmo + TMO_W'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_adv) begin
         if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
         end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = S_WR_SETUP;
         end
      end else begin
         w_idx_nxt = w_idx_nxt;
      end
   end

   // Bus request decoded from the state being entered, so the APB pins are flops
   always_comb begin
      w_psel_nxt    = 1'b0;
      w_penable_nxt = 1'b0;
      w_pwrite_nxt  = 1'b0;
      w_paddr_nxt   = 8'd0;
      w_pwdata_nxt  = 8'd0;
      case (w_state_nxt)
         S_WR_SETUP, S_WR_ACCESS: begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = (w_state_nxt == S_WR_ACCESS);
            w_pwrite_nxt  = 1'b1;
            w_paddr_nxt   = w_idx_nxt;
            w_pwdata_nxt  = prio_at(w_snap_nxt, w_idx_nxt);
         end
         S_RD_SETUP, S_RD_ACCESS: begin
            w_psel_nxt    = 1'b1;
            w_penable_nxt = (w_state_nxt == S_RD_ACCESS);
            w_paddr_nxt   = w_idx_nxt;
         end
         default: begin
            w_psel_nxt    = 1'b0;
         end
      endcase
   end

   // State, sequencing registers and registered outputs
   always_ff @(posedge pclk_i) begin
      if (prst_i) begin
         r_state    <= S_IDLE;
         r_idx      <= 8'd0;
         r_tmo      <= '0;
         r_snap     <= '0;
         r_verify   <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_err_addr <= 8'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_paddr    <= 8'd0;
         r_pwdata   <= 8'd0;
         r_pwrite   <= 1'b0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_tmo      <= w_tmo_nxt;
         r_snap     <= w_snap_nxt;
         r_verify   <= w_verify_nxt;
         r_err      <= w_err_nxt;
         r_err_code <= w_err_code_nxt;
         r_err_addr <= w_err_addr_nxt;
         r_busy     <= w_psel_nxt;
         r_done     <= (w_state_nxt == S_DONE);
         r_paddr    <= w_paddr_nxt;
         r_pwdata   <= w_pwdata_nxt;
         r_pwrite   <= w_pwrite_nxt;
         r_psel     <= w_psel_nxt;
         r_penable  <= w_penable_nxt;
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign err_o      = r_err;
   assign err_code_o = r_err_code;
   assign err_addr_o = r_err_addr;
   assign paddr_o    = r_paddr;
   assign pwdata_o   = r_pwdata;
   assign pwrite_o   = r_pwrite;
   assign psel_o     = r_psel;
   assign penable_o  = r_penable;

endmodule

// File: tb/tb_intr_prio_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_intr_prio_cfg_loader
// Directed bench for intr_prio_cfg_loader with a small APB slave model that
// stores written priorities and can insert wait states, corrupt a readback,
// raise pslverr or never answer on a chosen address.
// -----------------------------------------------------------------------------
module tb_intr_prio_cfg_loader;

   localparam int N  = 16;
   localparam int PW = 4;

   logic            pclk;
   logic            prst;
   logic            start;
   logic            verify_en;
   logic [N*PW-1:0] prio_table;
   logic            busy;
   logic            done;
   logic            err;
   logic [1:0]      err_code;
   logic [7:0]      err_addr;
   logic [7:0]      paddr;
   logic [7:0]      pwdata;
   logic            pwrite;
   logic            psel;
   logic            penable;
   logic [7:0]      prdata;
   logic            pready;
   logic            pslverr;

   int checks   = 0;
   int failures = 0;

   logic [3:0]      tbl_arr [N] = '{4'd10, 4'd7, 4'd5, 4'd15, 4'd6, 4'd3, 4'd8, 4'd4,
                                    4'd0, 4'd1, 4'd11, 4'd2, 4'd13, 4'd9, 4'd14, 4'd12};
   logic [N*PW-1:0] tbl_packed;
   logic [7:0]      mem [256];

   logic       wait_en      = 1'b0;
   logic       corrupt_en   = 1'b0;
   logic       perr_en      = 1'b0;
   logic       hang_en      = 1'b0;
   logic [7:0] wait_addr    = 8'd0;
   logic [7:0] corrupt_addr = 8'd0;
   logic [7:0] perr_addr    = 8'd0;
   logic [7:0] hang_addr    = 8'd0;

   int wcnt          = 0;
   int wr_tot        = 0;
   int rd_tot        = 0;
   int wdata_bad_tot = 0;
   int prot_bad_tot  = 0;
   int acc10_tot     = 0;

   intr_prio_cfg_loader #(.NUM_INTR(N), .PRIO_W(PW), .TIMEOUT_CYC(16)) dut (
      .pclk_i       (pclk),
      .prst_i       (prst),
      .start_i      (start),
      .verify_en_i  (verify_en),
      .prio_table_i (prio_table),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .err_code_o   (err_code),
      .err_addr_o   (err_addr),
      .paddr_o      (paddr),
      .pwdata_o     (pwdata),
      .pwrite_o     (pwrite),
      .psel_o       (psel),
      .penable_o    (penable),
      .prdata_i     (prdata),
      .pready_i     (pready),
      .pslverr_i    (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Slave response: two wait states on the chosen write, or no response at all
   assign pready  = psel && penable
                    && !(hang_en && paddr == hang_addr)
                    && !(wait_en && pwrite && paddr == wait_addr && wcnt < 2);
   assign pslverr = perr_en && pwrite && paddr == perr_addr;
   assign prdata  = (psel && penable && !pwrite)
                    ? ((corrupt_en && paddr == corrupt_addr) ? 8'h03 : mem[paddr])
                    : 8'h00;

   // Slave storage plus running transfer / protocol statistics
   always @(posedge pclk) begin
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
      if (psel && penable && pready) begin
         if (pwrite) begin
            wr_tot <= wr_tot + 1;
            if (!pslverr) mem[paddr] <= pwdata;
            if (pwdata !== {4'h0, tbl_arr[paddr[3:0]]}) wdata_bad_tot <= wdata_bad_tot + 1;
         end else begin
            rd_tot <= rd_tot + 1;
         end
      end
      if (psel && paddr == 8'd10) acc10_tot <= acc10_tot + 1;
      if ((penable && !psel) || (psel && done)) prot_bad_tot <= prot_bad_tot + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Start a sequence; return the cycle of done_o (start edge = cycle 0) or
   // the cycle stop_at. Optionally pulses start with other data at inject_at.
   task automatic run_seq(input logic ven, input int inject_at, input int stop_at,
                          output int dc, output logic err_at1);
      int n;
      bit fin;
      @(posedge pclk);
      @(negedge pclk);
      verify_en  = ven;
      prio_table = tbl_packed;
      start      = 1'b1;
      @(posedge pclk); #1;
      start     = 1'b0;
      verify_en = 1'b0;
      n         = 1;
      fin       = 1'b0;
      dc        = -1;
      err_at1   = err;
      while (!fin && n < 400) begin
         if (done || n == stop_at) begin
            dc  = n;
            fin = 1'b1;
         end else begin
            if (n == inject_at) begin
               start      = 1'b1;
               verify_en  = 1'b1;
               prio_table = ~tbl_packed;
            end else begin
               start      = 1'b0;
               verify_en  = 1'b0;
               prio_table = tbl_packed;
            end
            @(posedge pclk); #1;
            n++;
         end
      end
      start      = 1'b0;
      verify_en  = 1'b0;
      prio_table = tbl_packed;
   endtask

   initial begin
      int   dc;
      logic e1;
      int   w0, r0, b0, a0, bad;

      for (int i = 0; i < N; i++) tbl_packed[i*PW +: PW] = tbl_arr[i];
      prst       = 1'b1;
      start      = 1'b0;
      verify_en  = 1'b0;
      prio_table = '0;
      repeat (3) @(posedge pclk);
      #1;
      check("reset_outputs", {busy, done, err, err_code, err_addr, paddr, pwdata,
                              pwrite, psel, penable}, 32'd0);
      prst = 1'b0;

      // Plain load, no verify, zero wait states
      w0 = wr_tot; r0 = rd_tot; b0 = wdata_bad_tot;
      run_seq(1'b0, -1, -1, dc, e1);
      check("plain_done_cycle", dc, 32'd33);
      check("plain_err", {31'd0, err}, 32'd0);
      check("plain_busy_at_done", {31'd0, busy}, 32'd0);
      @(posedge pclk); #1;
      check("plain_done_one_cycle", {31'd0, done}, 32'd0);
      check("plain_writes", wr_tot - w0, 32'd16);
      check("plain_reads", rd_tot - r0, 32'd0);
      check("plain_wdata", wdata_bad_tot - b0, 32'd0);
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] !== {4'h0, tbl_arr[i]}) bad++;
      check("plain_regs", bad, 32'd0);

      // Verify with two wait states on the write to address 5
      wait_en = 1'b1; wait_addr = 8'd5;
      w0 = wr_tot; r0 = rd_tot;
      run_seq(1'b1, -1, -1, dc, e1);
      check("verify_done_cycle", dc, 32'd67);
      check("verify_err", {31'd0, err}, 32'd0);
      @(posedge pclk); #1;
      check("verify_writes", wr_tot - w0, 32'd16);
      check("verify_reads", rd_tot - r0, 32'd16);
      wait_en = 1'b0;

      // Slave error on the write to address 3
      perr_en = 1'b1; perr_addr = 8'd3;
      run_seq(1'b0, -1, -1, dc, e1);
      check("slverr_done_cycle", dc, 32'd9);
      check("slverr_flag", {31'd0, err}, 32'd1);
      check("slverr_code", {30'd0, err_code}, 32'd1);
      check("slverr_addr", {24'd0, err_addr}, 32'd3);
      check("slverr_busy", {31'd0, busy}, 32'd0);
      perr_en = 1'b0;

      // Corrupted readback of address 9
      corrupt_en = 1'b1; corrupt_addr = 8'd9;
      r0 = rd_tot; a0 = acc10_tot;
      run_seq(1'b1, -1, -1, dc, e1);
      check("rdbk_err_cleared_on_start", {31'd0, e1}, 32'd0);
      check("rdbk_done_cycle", dc, 32'd41);
      check("rdbk_flag", {31'd0, err}, 32'd1);
      check("rdbk_code", {30'd0, err_code}, 32'd3);
      check("rdbk_addr", {24'd0, err_addr}, 32'd9);
      @(posedge pclk); #1;
      check("rdbk_reads", rd_tot - r0, 32'd10);
      check("rdbk_no_addr10", acc10_tot - a0, 32'd0);
      corrupt_en = 1'b0;

      // Slave never ready at address 0
      hang_en = 1'b1; hang_addr = 8'd0;
      run_seq(1'b0, -1, -1, dc, e1);
      check("tmo_done_cycle", dc, 32'd18);
      check("tmo_code", {30'd0, err_code}, 32'd2);
      check("tmo_addr", {24'd0, err_addr}, 32'd0);
      @(posedge pclk); #1;
      check("tmo_bus_idle", {30'd0, psel, penable}, 32'd0);
      check("tmo_err_sticky", {31'd0, err}, 32'd1);
      hang_en = 1'b0;

      // Reset during the write access of address 7, then a clean reload
      run_seq(1'b0, -1, 16, dc, e1);
      check("rst_pre_addr", {24'd0, paddr}, 32'd7);
      check("rst_pre_access", {29'd0, psel, penable, pwrite}, 32'd7);
      prst = 1'b1;
      @(posedge pclk); #1;
      check("rst_bus_idle", {29'd0, psel, penable, pwrite}, 32'd0);
      check("rst_no_done", {30'd0, done, busy}, 32'd0);
      prst = 1'b0;
      w0 = wr_tot; r0 = rd_tot; b0 = wdata_bad_tot;
      run_seq(1'b0, 5, -1, dc, e1);
      check("reload_done_cycle", dc, 32'd33);
      check("reload_err", {31'd0, err}, 32'd0);
      @(posedge pclk); #1;
      check("reload_writes", wr_tot - w0, 32'd16);
      check("reload_busy_start_ignored", rd_tot - r0, 32'd0);
      check("reload_wdata", wdata_bad_tot - b0, 32'd0);

      check("protocol", prot_bad_tot, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/intr_prio_cfg_loader.md
Name: intr_prio_cfg_loader

Overview:
APB-style master sequencer that programs the NUM_INTR priority registers of interrupt_controller after reset or on software request. It walks index 0..NUM_INTR-1 and writes each priority to paddr = index. Optionally it reads each register back and compares it with the written value. It reports completion and the first error (slave error, timeout or readback mismatch) with the failing address, so the system never services interrupts with a half-programmed priority map.

Parameters:
NUM_INTR, 16, number of interrupt sources and priority registers (2..256)
PRIO_W, 4, width of one priority field; must be <= 8
TIMEOUT_CYC, 16, maximum ACCESS-phase cycles waiting for pready_i before a timeout error

Ports:
pclk_i  in  1  clock; all logic on the rising edge
prst_i  in  1  reset; synchronous, active-high
start_i  in  1  begin a load sequence; sampled only in IDLE
verify_en_i  in  1  enable per-register readback compare; sampled with start_i
prio_table_i  in  NUM_INTR*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W]; snapshotted on start
busy_o  out  1  high from the cycle after start is accepted until done_o
done_o  out  1  one-cycle pulse at end of sequence, successful or failed
err_o  out  1  sticky error flag; cleared when the next start is accepted
err_code_o  out  2  0 none, 1 pslverr, 2 timeout, 3 readback mismatch
err_addr_o  out  8  paddr of the failing access
paddr_o  out  8  APB address = register index
pwdata_o  out  8  zero-extended priority
pwrite_o  out  1  1 write, 0 read
psel_o  out  1  APB select
penable_o  out  1  APB enable
prdata_i  in  8  read data
pready_i  in  1  slave ready
pslverr_i  in  1  slave error, valid with pready_i

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, timeout counter 0. A reset asserted mid-sequence returns the bus to idle (psel/penable/pwrite 0) at the next edge. done_o is not pulsed. The snapshot is discarded.
- FSM states: IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, DONE.
- IDLE:
  - start_i=1 latches prio_table_i and verify_en_i, clears err_o/err_code_o/err_addr_o, sets index=0 and moves to WR_SETUP.
  - start_i while busy_o=1 is ignored.
- WR_SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=index, pwdata={zeros, prio[index]}.
- WR_ACCESS: penable=1 with the same address, data and direction; the timeout counter increments each cycle pready_i=0. On pready_i=1:
  - pslverr_i=1: record code 1 and paddr, go to DONE.
  - otherwise: go to RD_SETUP if verify is latched, else advance.
- RD_SETUP / RD_ACCESS: same phasing with pwrite=0 and pwdata=0. On pready_i=1:
  - pslverr_i=1 gives code 1.
  - prdata_i != zero-extended prio[index] gives code 3; upper bits must also be 0.
  - otherwise advance.
- Timeout: the counter reaching TIMEOUT_CYC in any ACCESS state records code 2, drops the bus and goes to DONE. The counter clears on every SETUP.
- Advance: if index == NUM_INTR-1, go to DONE; else index+1 and go to WR_SETUP.
- DONE (1 cycle): bus idle, done_o=1, busy_o=0 in the same cycle, err_o=1 if an error was recorded; next state IDLE.
- Only the first error is recorded; the sequence aborts on that error and the remaining registers are left untouched.
- Latency with zero wait states (start sampled at cycle 0): first WR_SETUP at cycle 1.
  - No verify: done_o at cycle 2*NUM_INTR+1.
  - With verify: done_o at cycle 4*NUM_INTR+1.
  - Each wait state adds one cycle.
- psel_o/penable_o are never high in IDLE or DONE, and penable_o is never high without psel_o.

Test Plan:
- Table {10,7,5,15,6,3,8,4,0,1,11,2,13,9,14,12}, verify off, pready tied 1 -> 16 writes to addr 0..15 with matching pwdata; done_o at cycle 33; err_o=0; the controller model's priority regs match the table.
- Same table, verify on, slave inserts 2 wait states on addr 5 -> 32 transfers, done_o at cycle 67, err_o=0.
- Verify on, slave model corrupts readback of addr 9 to 8'h03 -> abort after the read of addr 9; err_code_o=3, err_addr_o=9, no access to addr 10.
- pslverr_i=1 on the write to addr 3 -> done_o pulse; err_code_o=1, err_addr_o=3; busy_o low.
- pready_i held 0 at addr 0 -> timeout after 16 ACCESS cycles; err_code_o=2, err_addr_o=0, bus idle afterwards.
- prst_i pulsed during WR_ACCESS of addr 7, then start_i re-asserted -> bus idle the next cycle, no done_o; a fresh sequence starts at addr 0 and completes cleanly. A start_i pulse while busy has no effect.
